// File: rtl/genius_button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : genius_button_conditioner_pkg
// Description : Shared definitions for the Genius button input stage: FSM
//               state encodings, default sizing and a one-hot helper. The game
//               FSM and the debug display decoders reuse these definitions.
// Revision    : 1.0 - initial release
// ============================================================================
package genius_button_conditioner_pkg;

    localparam int DEFAULT_N_BOTOES        = 7;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_CNT_W           = 16;

    // Conditioner states; the encodings are visible on db_estado.
    typedef enum logic [1:0] {
        OCIOSO      = 2'b00,
        FILTRANDO   = 2'b01,
        PRESSIONADO = 2'b10,
        SOLTANDO    = 2'b11
    } estado_t;

    // True when exactly one bit of the (zero-extended) vector is set.
    function automatic logic ehUnitario(input logic [31:0] vetor);
        return (vetor != 32'd0) && ((vetor & (vetor - 32'd1)) == 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/genius_button_conditioner_sincronizador_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sincronizador_2ff
// Description : Two-flop synchronizer for a vector of asynchronous levels.
//               Each bit is synchronized independently; q lags d by two
//               clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sincronizador_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage gives it a cycle to settle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/genius_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : genius_button_conditioner
// Description : Conditions the raw Genius push-buttons into a debounced,
//               one-hot vector. Emits one jogada_valida pulse per accepted
//               single-button press, one multiplo pulse per rejected
//               multi-button press, and requires a fully debounced release
//               before any new press can be accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module genius_button_conditioner
    import genius_button_conditioner_pkg::*;
#(
    parameter int N_BOTOES        = DEFAULT_N_BOTOES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_BOTOES-1:0] botoes_raw,
    output logic [N_BOTOES-1:0] botoes,
    output logic                jogada_valida,
    output logic                multiplo,
    output logic [1:0]          db_estado
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_UM  = CNT_W'(1);

    logic [N_BOTOES-1:0] w_sSync;
    logic                w_candidatoUnitario;
    logic                w_fimContagem;

    estado_t             r_estado;
    logic [N_BOTOES-1:0] r_candidato;
    logic [CNT_W-1:0]    r_contador;
    logic [N_BOTOES-1:0] r_botoes;
    logic                r_jogadaValida;
    logic                r_multiplo;

    sincronizador_2ff #(
        .WIDTH (N_BOTOES)
    ) u_sincronizador (
        .clock (clock),
        .reset (reset),
        .d     (botoes_raw),
        .q     (w_sSync)
    );

    assign w_candidatoUnitario = ehUnitario(32'(r_candidato));
    assign w_fimContagem       = (r_contador == c_CNT_MAX);

    // Debounce FSM: the counter is cleared on every state entry so it can
    // never run past DEBOUNCE_CYCLES-1; all outputs are registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado       <= OCIOSO;
            r_candidato    <= '0;
            r_contador     <= '0;
            r_botoes       <= '0;
            r_jogadaValida <= 1'b0;
            r_multiplo     <= 1'b0;
        end else begin
            r_jogadaValida <= 1'b0;
            r_multiplo     <= 1'b0;

            case (r_estado)
                OCIOSO: begin
                    r_botoes <= '0;
                    if (enable && (w_sSync != '0)) begin
                        r_candidato <= w_sSync;
                        r_contador  <= '0;
                        r_estado    <= FILTRANDO;
                    end
                end

                FILTRANDO: begin
                    r_botoes <= '0;
                    if (!enable) begin
                        // Disabled mid-filter: wait for a clean release.
                        r_contador <= '0;
                        r_estado   <= SOLTANDO;
                    end else if (w_sSync == '0) begin
                        // Short glitch, nothing was pressed long enough.
                        r_contador <= '0;
                        r_estado   <= OCIOSO;
                    end else if (w_sSync != r_candidato) begin
                        // Pattern still moving: restart on the new pattern.
                        r_candidato <= w_sSync;
                        r_contador  <= '0;
                    end else if (w_fimContagem) begin
                        r_contador <= '0;
                        if (w_candidatoUnitario) begin
                            r_botoes       <= r_candidato;
                            r_jogadaValida <= 1'b1;
                            r_estado       <= PRESSIONADO;
                        end else begin
                            r_multiplo <= 1'b1;
                            r_estado   <= SOLTANDO;
                        end
                    end else begin
                        r_contador <= r_contador + c_CNT_UM;
                    end
                end

                PRESSIONADO: begin
                    if (!enable || (w_sSync != r_candidato)) begin
                        r_botoes   <= '0;
                        r_contador <= '0;
                        r_estado   <= SOLTANDO;
                    end else begin
                        r_botoes <= r_candidato;
                    end
                end

                SOLTANDO: begin
                    r_botoes <= '0;
                    if (w_sSync != '0) begin
                        // Any activity restarts the all-released interval.
                        r_contador <= '0;
                    end else if (w_fimContagem) begin
                        r_contador <= '0;
                        r_estado   <= OCIOSO;
                    end else begin
                        r_contador <= r_contador + c_CNT_UM;
                    end
                end

                default: begin
                    r_botoes   <= '0;
                    r_contador <= '0;
                    r_estado   <= OCIOSO;
                end
            endcase
        end
    end

    assign botoes        = r_botoes;
    assign jogada_valida = r_jogadaValida;
    assign multiplo      = r_multiplo;
    assign db_estado     = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_genius_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_genius_button_conditioner
// Description : Self-checking bench for genius_button_conditioner with
//               DEBOUNCE_CYCLES=4. Cycle-exact vectors with hand-derived
//               expected outputs, plus asynchronous reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_genius_button_conditioner;

    localparam int N   = 7;
    localparam int DEB = 4;

    localparam logic [N-1:0] B0 = 7'b0000001;
    localparam logic [N-1:0] B1 = 7'b0000010;
    localparam logic [N-1:0] B2 = 7'b0000100;
    localparam logic [N-1:0] B3 = 7'b0001000;
    localparam logic [N-1:0] B4 = 7'b0010000;
    localparam logic [N-1:0] B5 = 7'b0100000;
    localparam logic [N-1:0] B6 = 7'b1000000;
    localparam logic [N-1:0] M  = 7'b0000011;
    localparam logic [N-1:0] Z  = 7'b0000000;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] botoes_raw;
    logic [N-1:0] botoes;
    logic         jogada_valida;
    logic         multiplo;
    logic [1:0]   db_estado;

    genius_button_conditioner #(
        .N_BOTOES        (N),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .botoes_raw    (botoes_raw),
        .botoes        (botoes),
        .jogada_valida (jogada_valida),
        .multiplo      (multiplo),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] raw;
        logic         en;
        int           n;
        logic [N-1:0] bot;
        logic         jv;
        logic         mul;
        logic [1:0]   est;
    } vec_t;

    typedef struct {
        logic [10:0] esperado;
        string       nome;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic addVec(input logic [N-1:0] raw, input logic en, input int n,
                          input logic [N-1:0] bot, input logic jv, input logic mul,
                          input logic [1:0] est);
        vec_t v;
        v.raw = raw; v.en = en; v.n = n;
        v.bot = bot; v.jv = jv; v.mul = mul; v.est = est;
        vecs.push_back(v);
    endtask

    // Release of an accepted press: two cycles of sync delay, four debounced
    // released cycles in SOLTANDO, then back in OCIOSO.
    task automatic addRelease(input logic [N-1:0] bot);
        addVec(Z, 1'b1, 2, bot, 1'b0, 1'b0, 2'b10);
        addVec(Z, 1'b1, 4, Z,   1'b0, 1'b0, 2'b11);
        addVec(Z, 1'b1, 2, Z,   1'b0, 1'b0, 2'b00);
    endtask

    task automatic check(input string nome, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got botoes=%b jv=%b mult=%b est=%b, expected botoes=%b jv=%b mult=%b est=%b",
                     nome, act[10:4], act[3], act[2], act[1:0], exp[10:4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    function automatic logic [10:0] saidas();
        return {botoes, jogada_valida, multiplo, db_estado};
    endfunction

    // Drive one cycle of stimulus (just after a falling edge), queue the
    // outputs expected after the next rising edge, and compare them at the
    // following falling edge.
    task automatic ciclo(input logic [N-1:0] raw, input logic en,
                         input logic [10:0] exp, input string nome);
        sb_t e;
        botoes_raw = raw;
        enable     = en;
        e.esperado = exp;
        e.nome     = nome;
        sbq.push_back(e);
        @(negedge clock);
        e = sbq.pop_front();
        check(e.nome, saidas(), e.esperado);
    endtask

    task automatic pressToPressionado(input logic [N-1:0] b, input string tag);
        for (int k = 0; k < 2; k++) ciclo(b, 1'b1, {Z, 1'b0, 1'b0, 2'b00}, tag);
        for (int k = 0; k < DEB; k++) ciclo(b, 1'b1, {Z, 1'b0, 1'b0, 2'b01}, tag);
        ciclo(b, 1'b1, {b, 1'b1, 1'b0, 2'b10}, tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        enable     = 1'b1;
        botoes_raw = Z;
        @(negedge clock);
        @(negedge clock);
        check("reset_state", saidas(), 11'd0);
        reset = 1'b1;

        // Clean press of bit 2
        addVec(B2, 1'b1, 2,  Z,  1'b0, 1'b0, 2'b00);
        addVec(B2, 1'b1, 4,  Z,  1'b0, 1'b0, 2'b01);
        addVec(B2, 1'b1, 1,  B2, 1'b1, 1'b0, 2'b10);
        addVec(B2, 1'b1, 13, B2, 1'b0, 1'b0, 2'b10);
        addRelease(B2);
        // Bouncing bit 2, then held
        addVec(B2, 1'b1, 2, Z,  1'b0, 1'b0, 2'b00);
        addVec(Z,  1'b1, 2, Z,  1'b0, 1'b0, 2'b01);
        addVec(B2, 1'b1, 2, Z,  1'b0, 1'b0, 2'b00);
        addVec(Z,  1'b1, 2, Z,  1'b0, 1'b0, 2'b01);
        addVec(B2, 1'b1, 2, Z,  1'b0, 1'b0, 2'b00);
        addVec(B2, 1'b1, 4, Z,  1'b0, 1'b0, 2'b01);
        addVec(B2, 1'b1, 1, B2, 1'b1, 1'b0, 2'b10);
        addVec(B2, 1'b1, 3, B2, 1'b0, 1'b0, 2'b10);
        addRelease(B2);
        // Two buttons at once
        addVec(M, 1'b1, 2, Z, 1'b0, 1'b0, 2'b00);
        addVec(M, 1'b1, 4, Z, 1'b0, 1'b0, 2'b01);
        addVec(M, 1'b1, 1, Z, 1'b0, 1'b1, 2'b11);
        addVec(M, 1'b1, 3, Z, 1'b0, 1'b0, 2'b11);
        addVec(Z, 1'b1, 5, Z, 1'b0, 1'b0, 2'b11);
        addVec(Z, 1'b1, 2, Z, 1'b0, 1'b0, 2'b00);
        // Long hold, short release, re-press, full release, press again
        addVec(B0, 1'b1, 2,  Z,  1'b0, 1'b0, 2'b00);
        addVec(B0, 1'b1, 4,  Z,  1'b0, 1'b0, 2'b01);
        addVec(B0, 1'b1, 1,  B0, 1'b1, 1'b0, 2'b10);
        addVec(B0, 1'b1, 23, B0, 1'b0, 1'b0, 2'b10);
        addVec(Z,  1'b1, 2,  B0, 1'b0, 1'b0, 2'b10);
        addVec(B0, 1'b1, 6,  Z,  1'b0, 1'b0, 2'b11);
        addVec(Z,  1'b1, 5,  Z,  1'b0, 1'b0, 2'b11);
        addVec(Z,  1'b1, 1,  Z,  1'b0, 1'b0, 2'b00);
        addVec(B0, 1'b1, 2,  Z,  1'b0, 1'b0, 2'b00);
        addVec(B0, 1'b1, 4,  Z,  1'b0, 1'b0, 2'b01);
        addVec(B0, 1'b1, 1,  B0, 1'b1, 1'b0, 2'b10);
        addVec(B0, 1'b1, 3,  B0, 1'b0, 1'b0, 2'b10);
        addRelease(B0);
        // Enable dropped while pressed, re-enabled with button still held
        addVec(B1, 1'b1, 2, Z,  1'b0, 1'b0, 2'b00);
        addVec(B1, 1'b1, 4, Z,  1'b0, 1'b0, 2'b01);
        addVec(B1, 1'b1, 1, B1, 1'b1, 1'b0, 2'b10);
        addVec(B1, 1'b1, 2, B1, 1'b0, 1'b0, 2'b10);
        addVec(B1, 1'b0, 3, Z,  1'b0, 1'b0, 2'b11);
        addVec(B1, 1'b1, 5, Z,  1'b0, 1'b0, 2'b11);
        addVec(Z,  1'b1, 5, Z,  1'b0, 1'b0, 2'b11);
        addVec(Z,  1'b1, 2, Z,  1'b0, 1'b0, 2'b00);
        addVec(B1, 1'b1, 2, Z,  1'b0, 1'b0, 2'b00);
        addVec(B1, 1'b1, 4, Z,  1'b0, 1'b0, 2'b01);
        addVec(B1, 1'b1, 1, B1, 1'b1, 1'b0, 2'b10);
        addVec(B1, 1'b1, 2, B1, 1'b0, 1'b0, 2'b10);
        addRelease(B1);
        // Pattern change while filtering: candidate follows the new button
        addVec(B4, 1'b1, 2, Z,  1'b0, 1'b0, 2'b00);
        addVec(B4, 1'b1, 1, Z,  1'b0, 1'b0, 2'b01);
        addVec(B5, 1'b1, 6, Z,  1'b0, 1'b0, 2'b01);
        addVec(B5, 1'b1, 1, B5, 1'b1, 1'b0, 2'b10);
        addVec(B5, 1'b1, 2, B5, 1'b0, 1'b0, 2'b10);
        addRelease(B5);
        // Enable dropped while filtering
        addVec(B3, 1'b1, 2, Z, 1'b0, 1'b0, 2'b00);
        addVec(B3, 1'b1, 2, Z, 1'b0, 1'b0, 2'b01);
        addVec(B3, 1'b0, 1, Z, 1'b0, 1'b0, 2'b11);
        addVec(B3, 1'b1, 3, Z, 1'b0, 1'b0, 2'b11);
        addVec(Z,  1'b1, 5, Z, 1'b0, 1'b0, 2'b11);
        addVec(Z,  1'b1, 2, Z, 1'b0, 1'b0, 2'b00);
        // Presses ignored while disabled
        addVec(B3, 1'b0, 6, Z, 1'b0, 1'b0, 2'b00);
        addVec(Z,  1'b0, 3, Z, 1'b0, 1'b0, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                ciclo(vecs[i].raw, vecs[i].en,
                      {vecs[i].bot, vecs[i].jv, vecs[i].mul, vecs[i].est},
                      $sformatf("vec%0d.c%0d", i, k));
            end
        end

        // Asynchronous reset in the middle of FILTRANDO
        for (int k = 0; k < 2; k++) ciclo(B6, 1'b1, {Z, 1'b0, 1'b0, 2'b00}, "rstf_pre");
        for (int k = 0; k < 2; k++) ciclo(B6, 1'b1, {Z, 1'b0, 1'b0, 2'b01}, "rstf_filt");
        #2 reset = 1'b0;
        #1 check("rst_mid_filtrando", saidas(), 11'd0);
        @(negedge clock);
        botoes_raw = Z;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) ciclo(Z, 1'b1, {Z, 1'b0, 1'b0, 2'b00}, "rstf_post");

        // Asynchronous reset while PRESSIONADO (botoes nonzero)
        pressToPressionado(B6, "rstp_press");
        ciclo(B6, 1'b1, {B6, 1'b0, 1'b0, 2'b10}, "rstp_hold");
        #2 reset = 1'b0;
        #1 check("rst_mid_pressionado", saidas(), 11'd0);
        @(negedge clock);
        botoes_raw = Z;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) ciclo(Z, 1'b1, {Z, 1'b0, 1'b0, 2'b00}, "rstp_post");

        // Same button pressed again after reset is accepted normally
        pressToPressionado(B6, "after_rst");
        ciclo(B6, 1'b1, {B6, 1'b0, 1'b0, 2'b10}, "after_rst_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/genius_button_conditioner.md
Name: genius_button_conditioner

Overview:
Input stage directly upstream of the Genius datapath. Conditions the 7 raw, asynchronous push-buttons into a clean, debounced, one-hot vector that the datapath edge-detects and registers. Asserts a single-cycle press pulse per accepted press and rejects multi-button presses. It lets the datapath treat any nonzero button vector as one legitimate move.

Parameters:
N_BOTOES, 7, number of button inputs.
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or release (1 ms at 50 MHz); minimum 2.
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
clock  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
enable  in  1  high = accept presses; low = ignore and force release-wait.
botoes_raw  in  N_BOTOES  raw button levels, asynchronous, 1 = pressed.
botoes  out  N_BOTOES  debounced one-hot vector; nonzero only in PRESSIONADO.
jogada_valida  out  1  one-cycle pulse on acceptance of a single-button press.
multiplo  out  1  one-cycle pulse when a debounced press has more than one bit set.
db_estado  out  2  current FSM state for debug displays.

Behaviour:
- Reset (reset=0, async): sync flops=0, candidato=0, contador=0, state=OCIOSO. botoes=0, jogada_valida=0, multiplo=0, db_estado=2'b00.
- Synchronizer: 2-FF per bit; s_sync = botoes_raw delayed 2 cycles. The FSM sees only s_sync.
- States and encodings: OCIOSO=00, FILTRANDO=01, PRESSIONADO=10, SOLTANDO=11.
- OCIOSO: if enable=1 and s_sync!=0: candidato<=s_sync, contador<=0, go FILTRANDO. Otherwise stay.
- FILTRANDO:
  - enable=0: go SOLTANDO, contador<=0.
  - s_sync==0: go OCIOSO (glitch rejected, no pulse).
  - s_sync!=candidato: candidato<=s_sync, contador<=0.
  - contador==DEBOUNCE_CYCLES-1 with candidato one-hot: go PRESSIONADO, jogada_valida=1 for that one cycle.
  - contador==DEBOUNCE_CYCLES-1 with more than one bit set: multiplo=1 for one cycle, go SOLTANDO, contador<=0.
  - Otherwise contador++.
- PRESSIONADO:
  - botoes=candidato, held constant.
  - s_sync!=candidato (release or change): go SOLTANDO, contador<=0, botoes=0 from the next cycle.
  - enable=0: same as above.
- SOLTANDO:
  - s_sync!=0: contador<=0.
  - s_sync==0 and contador==DEBOUNCE_CYCLES-1: go OCIOSO.
  - Otherwise contador++.
  - botoes=0.
- Latency: a clean press stable from cycle t at botoes_raw enters FILTRANDO at t+3. jogada_valida and botoes are valid at t+3+DEBOUNCE_CYCLES. botoes rises in the same cycle as jogada_valida.
- Outputs are registered. jogada_valida and multiplo are never high together, and neither is ever high for more than one cycle.
- A new press is never accepted before a full debounced all-released interval. Holding a button therefore never produces a second pulse.
- Mid-operation reset: all state returns to reset values immediately (async assert). Deassertion is taken as synchronous to the clock by the surrounding reset synchronizer.
- Counter never wraps: it is cleared on every state entry and saturates by state exit at DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package/include: state encodings (OCIOSO/FILTRANDO/PRESSIONADO/SOLTANDO) and the default DEBOUNCE_CYCLES. The game FSM and debug decoders reuse these.
- One sub-module: sincronizador_2ff (parameter WIDTH; clock, reset active-low async, d, q). It is instantiated once with WIDTH=N_BOTOES.
- The FSM, counter and one-hot check live in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and enable=1 unless stated.
1. Clean press: botoes_raw=7'b0000100 held 20 cycles from t0 -> jogada_valida=1 exactly at t0+7 for one cycle; botoes=0000100 from t0+7 until release; db_estado=10.
2. Bounce: toggle bit 2 every 2 cycles for 10 cycles, then hold -> no pulse during bouncing; exactly one jogada_valida 7 cycles after the last edge.
3. Multi-press: botoes_raw=7'b0000011 held 10 cycles -> multiplo pulse at t0+7, jogada_valida never asserted, botoes stays 0, db_estado=11 until 4 released cycles elapse.
4. Hold then re-press: hold bit 0 for 30 cycles -> one pulse only. Release 2 cycles, press again -> no new acceptance until release has been stable 4 cycles; the second press then yields exactly one pulse.
5. Enable drop: enable=0 while in PRESSIONADO -> botoes=0 next cycle, state SOLTANDO. Re-enable with button still held -> no pulse until release plus a new press.
6. Async reset: assert reset=0 mid-FILTRANDO between clock edges -> all outputs 0 and db_estado=00 immediately, with no clock edge needed.
